// File: rtl/spi_target_pkg.sv
// Shared constants for the SPI target: default word width, synchronizer depth and idle fill word.
// The link is fixed to SPI mode 0 (CPOL=0, CPHA=0).
package spi_target_pkg;

  localparam int         SPI_DEFAULT_DW      = 8;
  localparam int         SPI_DEFAULT_SYNC    = 2;
  localparam logic [7:0] SPI_TX_IDLE_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one SPI pad input, with a selectable reset level so that
// an idle pad (CS high, SCK low) produces no spurious edge when reset is released.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ff <= {STAGES{RESET_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target oversampled in the system clock, with valid/ready rx and tx word streams.
// Define SPI_TARGET_LSB_FIRST_EN to shift words LSB first in both directions (default MSB first).
module spi_target
  import spi_target_pkg::*;
#(
  parameter int                    DATA_WIDTH  = SPI_DEFAULT_DW,
  parameter int                    SYNC_STAGES = SPI_DEFAULT_SYNC,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE     = DATA_WIDTH'(SPI_TX_IDLE_DEFAULT)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  spi_sck_i,
  input  logic                  spi_cs_n_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  cs_active_o,
  output logic                  overrun_o,
  output logic                  underrun_o
);

  localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sck_s, cs_n_s, mosi_s;
  logic sck_d, cs_n_d;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clock(clock), .reset_n(reset_n), .d(spi_sck_i), .q(sck_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clock(clock), .reset_n(reset_n), .d(spi_cs_n_i), .q(cs_n_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset_n(reset_n), .d(spi_mosi_i), .q(mosi_s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_d  <= 1'b0;
      cs_n_d <= 1'b1;
    end else begin
      sck_d  <= sck_s;
      cs_n_d <= cs_n_s;
    end
  end

  logic sck_rise, sck_fall, cs_fall, cs_rise;
  logic cs_active, word_done, load_point;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] rx_shift, tx_shift, rx_next, tx_next;

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_n_s & cs_n_d;
  assign cs_rise  = cs_n_s & ~cs_n_d;

  // A load point opens the frame, and recurs on the falling edge that follows each completed word.
  assign load_point = cs_fall | (cs_active & sck_fall & (bit_cnt == '0));

`ifdef SPI_TARGET_LSB_FIRST_EN
  assign rx_next    = {mosi_s, rx_shift[DATA_WIDTH-1:1]};
  assign tx_next    = {1'b0, tx_shift[DATA_WIDTH-1:1]};
  assign spi_miso_o = tx_shift[0];
`else
  assign rx_next    = {rx_shift[DATA_WIDTH-2:0], mosi_s};
  assign tx_next    = {tx_shift[DATA_WIDTH-2:0], 1'b0};
  assign spi_miso_o = tx_shift[DATA_WIDTH-1];
`endif

  assign spi_miso_oe_o = cs_active;
  assign cs_active_o   = cs_active;
  assign tx_ready_o    = load_point;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_active <= 1'b0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (cs_rise) begin
        cs_active <= 1'b0;
        bit_cnt   <= '0;
      end else if (cs_fall) begin
        cs_active <= 1'b1;
        bit_cnt   <= '0;
      end else if (cs_active && sck_rise) begin
        rx_shift <= rx_next;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt   <= '0;
          word_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift   <= TX_IDLE;
      underrun_o <= 1'b0;
    end else begin
      underrun_o <= 1'b0;
      if (load_point) begin
        tx_shift   <= tx_valid_i ? tx_data_i : TX_IDLE;
        underrun_o <= ~tx_valid_i;
      end else if (cs_active && sck_fall) begin
        tx_shift <= tx_next;
      end
    end
  end

  // A completed word is only dropped when the holding register is full and not being drained.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (word_done) begin
        if (rx_valid_o && !rx_ready_i) begin
          overrun_o <= 1'b1;
        end else begin
          rx_data_o  <= rx_shift;
          rx_valid_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a bit-banged mode-0 host drives the pads, a monitor
// scoreboards rx words and counts flag pulses, and a feeder serves the tx stream.
module tb_spi_target;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       sck, cs_n, mosi;
  logic       miso, miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       cs_active, overrun, underrun;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int last_rise_cyc = 0;
  int cs_fall_cyc = 0;
  int last_lat = -1;
  int ur_cnt = 0, ov_cnt = 0, rdy_cnt = 0;
  int last_ready_cyc = 0;
  int ur0, ov0, rd0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  spi_target u_dut (
    .clock(clock),
    .reset_n(reset_n),
    .spi_sck_i(sck),
    .spi_cs_n_i(cs_n),
    .spi_mosi_i(mosi),
    .spi_miso_o(miso),
    .spi_miso_oe_o(miso_oe),
    .rx_data_o(rx_data),
    .rx_valid_o(rx_valid),
    .rx_ready_i(rx_ready),
    .tx_data_i(tx_data),
    .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .cs_active_o(cs_active),
    .overrun_o(overrun),
    .underrun_o(underrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Rx scoreboard and flag pulse counters, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (underrun) ur_cnt++;
      if (overrun)  ov_cnt++;
      if (rx_valid && rx_ready) begin
        last_lat = cyc - last_rise_cyc;
        if (rx_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_extra: got %0h expected no word", rx_data);
        end else begin
          check("rx_word", rx_data, rx_q.pop_front());
        end
      end
    end
  end

  // Tx feeder: presents queued words, retires one after each accepted load point.
  initial begin
    logic adv;
    adv = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    forever begin
      @(negedge clock);
      if (adv) begin
        tx_valid = 1'b0;
        adv = 1'b0;
      end
      if (!tx_valid && tx_q.size() > 0) begin
        tx_data = tx_q.pop_front();
        tx_valid = 1'b1;
      end
      if (tx_ready) begin
        rdy_cnt++;
        last_ready_cyc = cyc;
        if (tx_valid) adv = 1'b1;
      end
    end
  end

  task automatic cs_low();
    cs_n = 1'b0;
    cs_fall_cyc = cyc;
    wait_clk(8);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic host_bit(input logic b, output logic got);
    mosi = b;
    wait_clk(8);
    sck = 1'b1;
    last_rise_cyc = cyc;
    got = miso;
    wait_clk(8);
    sck = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] mo, input logic [7:0] exp_mi);
    logic [7:0] got;
    for (int i = 7; i >= 0; i--) host_bit(mo[i], got[i]);
    wait_clk(8);
    check("miso_byte", got, exp_mi);
  endtask

  initial begin
    logic dummy;
    reset_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; rx_ready = 1'b1;
    wait_clk(3);
    check("rst_miso", miso, 1);
    check("rst_oe", miso_oe, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_cs_active", cs_active, 0);
    check("rst_flags", {overrun, underrun}, 0);
    reset_n = 1'b1;
    wait_clk(4);
    check("idle_cs_active", cs_active, 0);

    // Receive A5 with nothing offered on tx: idle word goes out, two load points underrun.
    ur0 = ur_cnt;
    rx_q.push_back(8'hA5);
    cs_low();
    check("frame_cs_active", cs_active, 1);
    check("frame_oe", miso_oe, 1);
    xfer(8'hA5, 8'hFF);
    cs_high();
    check("end_oe", miso_oe, 0);
    check("a5_latency", last_lat, 4);
    check("a5_underruns", ur_cnt - ur0, 2);
    check("a5_drained", rx_q.size(), 0);

    // Tx word offered before CS: taken at the CS-fall load point.
    tx_q.push_back(8'h3C);
    wait_clk(2);
    ur0 = ur_cnt; rd0 = rdy_cnt;
    cs_low();
    check("cs_ready_pulses", rdy_cnt - rd0, 1);
    check("cs_ready_delay", last_ready_cyc - cs_fall_cyc, 2);
    check("cs_no_underrun", ur_cnt - ur0, 0);
    rx_q.push_back(8'hC3);
    xfer(8'hC3, 8'h3C);
    cs_high();
    check("3c_ready_pulses", rdy_cnt - rd0, 2);
    check("3c_underruns", ur_cnt - ur0, 1);

    // Two-word frame, second word not supplied; a filler covers the trailing load point.
    tx_q.push_back(8'h3C);
    wait_clk(2);
    ur0 = ur_cnt;
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h02);
    cs_low();
    xfer(8'h01, 8'h3C);
    tx_q.push_back(8'h00);
    xfer(8'h02, 8'hFF);
    cs_high();
    check("2w_underruns", ur_cnt - ur0, 1);
    check("2w_drained", rx_q.size(), 0);

    // Consumer stalled: second word is dropped with one overrun pulse.
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    rx_q.push_back(8'h11);
    cs_low();
    xfer(8'h11, 8'hFF);
    xfer(8'h22, 8'hFF);
    cs_high();
    check("ovr_pulses", ov_cnt - ov0, 1);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_held", rx_data, 8'h11);
    rx_ready = 1'b1;
    wait_clk(3);
    check("ovr_valid_clear", rx_valid, 0);
    check("ovr_drained", rx_q.size(), 0);

    // CS raised after five bits: partial word discarded, next frame framed cleanly.
    cs_low();
    for (int i = 0; i < 5; i++) host_bit(1'b1, dummy);
    wait_clk(8);
    cs_high();
    check("abort_no_valid", rx_valid, 0);
    rx_q.push_back(8'h5A);
    cs_low();
    xfer(8'h5A, 8'hFF);
    cs_high();
    check("abort_drained", rx_q.size(), 0);

    // Reset in the middle of a word takes effect without a clock edge.
    tx_q.push_back(8'h3C);
    wait_clk(2);
    cs_low();
    host_bit(1'b1, dummy);
    wait_clk(8);
    check("pre_rst_miso", miso, 0);
    reset_n = 1'b0;
    #1;
    check("async_rst_miso", miso, 1);
    check("async_rst_oe", miso_oe, 0);
    check("async_rst_cs_active", cs_active, 0);
    check("async_rst_rx_valid", rx_valid, 0);
    cs_n = 1'b1;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(4);
    rx_q.push_back(8'hA5);
    cs_low();
    xfer(8'hA5, 8'hFF);
    cs_high();
    check("post_rst_drained", rx_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
